// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD read and write paths: FSM state encoding,
// busy-flag bit position and default bus timing.
package lcd_pkg;

  // Bus-cycle phases shared by the reader and writer FSMs
  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StEnHi,
    StEnLo,
    StDone
  } lcd_state_e;

  // Busy flag position in the RS=0 status byte
  localparam int unsigned LCD_BF_BIT = 7;

  // Default timing: EN phase length and RS/RW setup, in system clocks
  localparam int unsigned LCD_CLK_DIV       = 16;
  localparam int unsigned LCD_SETUP_CYC     = 2;
  localparam int unsigned LCD_TIMEOUT_POLLS = 256;

  function automatic int unsigned lcd_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Phase timer: load a cycle count, count down, flag the last cycle of the phase.
// A load of N keeps the phase alive for N clocks; o_expire is high on the Nth.
module lcd_phase_timer #(
  parameter int unsigned Width = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  output logic             o_expire
);

  logic [Width-1:0] r_cnt;

  // Down-counter, parks at zero once the phase has run out
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = (r_cnt == Width'(1));

endmodule

// File: rtl/lcd_bus_reader.sv
// HD44780-style 8-bit bus reader: one RW=1 read cycle per host request, with optional
// busy-flag polling. Polling is compiled in with LCD_BUSY_POLL_EN; without it iPoll is
// ignored, every request is exactly one read and oTimeout stays 0.
module lcd_bus_reader
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_DIV       = LCD_CLK_DIV,
  parameter int unsigned SETUP_CYC     = LCD_SETUP_CYC,
  parameter int unsigned TIMEOUT_POLLS = LCD_TIMEOUT_POLLS
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iStart,
  input  logic       iRS,
  input  logic       iPoll,
  output logic [7:0] oDATA,
  output logic       oDone,
  output logic       oBusy,
  output logic       oTimeout,
  input  logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  localparam int unsigned TmrW = $clog2(lcd_max(CLK_DIV, SETUP_CYC)) + 1;

  lcd_state_e r_state;
  logic       r_start_d;
  logic [7:0] r_sample;
  logic [7:0] r_data;
  logic       r_done;
  logic       r_busy;
  logic       r_timeout;
  logic       r_rw;
  logic       r_en;
  logic       r_rs;

  logic            w_start;
  logic            w_expire;
  logic            w_tmr_load;
  logic [TmrW-1:0] w_tmr_val;
  logic            w_repoll;
  logic            w_poll_to;

  assign w_start = iStart & ~r_start_d;

  // Previous iStart level for rising-edge detection
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_start_d <= 1'b0;
    end else begin
      r_start_d <= iStart;
    end
  end

`ifdef LCD_BUSY_POLL_EN
  localparam int unsigned PollW = (TIMEOUT_POLLS > 1) ? $clog2(TIMEOUT_POLLS) : 1;

  logic             r_poll;
  logic [PollW-1:0] r_pcnt;
  logic             w_bf;
  logic             w_last;

  assign w_bf      = r_poll & r_sample[LCD_BF_BIT];
  assign w_last    = (r_pcnt == PollW'(TIMEOUT_POLLS - 1));
  assign w_repoll  = w_bf & ~w_last;
  assign w_poll_to = w_bf & w_last;

  // Poll mode is latched at accept and only applies to status reads (RS=0)
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_poll <= 1'b0;
      r_pcnt <= '0;
    end else if (r_state == StIdle && w_start) begin
      r_poll <= iPoll & ~iRS;
      r_pcnt <= '0;
    end else if (r_state == StEnLo && w_expire && w_repoll) begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end
`else
  logic w_unused_poll;

  assign w_unused_poll = iPoll | (TIMEOUT_POLLS == 0);
  assign w_repoll      = 1'b0;
  assign w_poll_to     = 1'b0;
`endif

  // Timer reload on every phase entry; SETUP is entered from IDLE or a repeated poll
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = TmrW'(CLK_DIV);
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = TmrW'(SETUP_CYC);
        end
      end
      StSetup: w_tmr_load = w_expire;
      StEnHi:  w_tmr_load = w_expire;
      StEnLo: begin
        if (w_expire && w_repoll) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = TmrW'(SETUP_CYC);
        end
      end
      default: ;
    endcase
  end

  lcd_phase_timer #(
    .Width (TmrW)
  ) u_timer (
    .i_clk      (iCLK),
    .i_rst_n    (iRST_N),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expire   (w_expire)
  );

  // Read-cycle FSM; EN tracks the EN_HI state exactly so RS/RW cannot move while EN=1
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state   <= StIdle;
      r_sample  <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_rw      <= 1'b0;
      r_en      <= 1'b0;
      r_rs      <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            r_state <= StSetup;
            r_rs    <= iRS;
            r_rw    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        StSetup: begin
          if (w_expire) begin
            r_state <= StEnHi;
            r_en    <= 1'b1;
          end
        end
        StEnHi: begin
          if (w_expire) begin
            r_state  <= StEnLo;
            r_en     <= 1'b0;
            r_sample <= LCD_DATA;
          end
        end
        StEnLo: begin
          if (w_expire) begin
            if (w_repoll) begin
              r_state <= StSetup;
            end else begin
              r_state   <= StDone;
              r_done    <= 1'b1;
              r_timeout <= w_poll_to;
              r_data    <= r_sample;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_rw    <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign oDATA    = r_data;
  assign oDone    = r_done;
  assign oBusy    = r_busy;
  assign oTimeout = r_timeout;
  assign LCD_RW   = r_rw;
  assign LCD_EN   = r_en;
  assign LCD_RS   = r_rs;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Randomized self-checking bench for lcd_bus_reader against a transaction-level model.
module tb_lcd_bus_reader;

  localparam int unsigned CLK_DIV       = 16;
  localparam int unsigned SETUP_CYC     = 2;
  localparam int unsigned TIMEOUT_POLLS = 8;
  localparam int unsigned LAT_FIRST     = SETUP_CYC + 2 * CLK_DIV + 1;
  localparam int unsigned LAT_EXTRA     = SETUP_CYC + 2 * CLK_DIV;
  localparam int          BUDGET        = LAT_FIRST + 20 * LAT_EXTRA;
`ifdef LCD_BUSY_POLL_EN
  localparam bit POLL_BUILD = 1'b1;
`else
  localparam bit POLL_BUILD = 1'b0;
`endif

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic       iStart = 1'b0;
  logic       iRS = 1'b0;
  logic       iPoll = 1'b0;
  logic [7:0] LCD_DATA = 8'h00;
  logic [7:0] oDATA;
  logic       oDone, oBusy, oTimeout, LCD_RW, LCD_EN, LCD_RS;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] tx_data [16];
  int         tx_len;

  always #5 iCLK = ~iCLK;

  lcd_bus_reader #(
    .CLK_DIV       (CLK_DIV),
    .SETUP_CYC     (SETUP_CYC),
    .TIMEOUT_POLLS (TIMEOUT_POLLS)
  ) dut (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .iStart   (iStart),
    .iRS      (iRS),
    .iPoll    (iPoll),
    .oDATA    (oDATA),
    .oDone    (oDone),
    .oBusy    (oBusy),
    .oTimeout (oTimeout),
    .LCD_DATA (LCD_DATA),
    .LCD_RW   (LCD_RW),
    .LCD_EN   (LCD_EN),
    .LCD_RS   (LCD_RS)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reads continue while polling and the busy flag is set, up to TIMEOUT_POLLS reads
  function automatic void model(input bit rs, input bit poll, output int pulses,
                                output logic [7:0] data, output bit to);
    bit poll_eff;
    poll_eff = POLL_BUILD && poll && !rs;
    pulses = 0;
    to = 1'b0;
    data = 8'h00;
    for (int k = 0; k < 64; k++) begin
      data = tx_data[(k < tx_len) ? k : tx_len - 1];
      pulses = k + 1;
      if (!poll_eff || !data[7]) break;
      if (k + 1 == int'(TIMEOUT_POLLS)) begin
        to = 1'b1;
        break;
      end
    end
  endfunction

  task automatic do_txn(input bit rs, input bit poll, input bit hold, input bit repulse,
                        input bit wiggle);
    int         exp_pulses, cyc, pulses, width, done_cyc, extra;
    logic [7:0] exp_data, got_data;
    bit         exp_to, got_to, prev_en, done_seen, proto_ok, width_ok;
    model(rs, poll, exp_pulses, exp_data, exp_to);
    @(negedge iCLK);
    iRS = rs;
    iPoll = poll;
    iStart = 1'b1;
    LCD_DATA = 8'($urandom);
    cyc = 0; pulses = 0; width = 0; done_cyc = -1; extra = 0;
    prev_en = 1'b0; done_seen = 1'b0; proto_ok = 1'b1; width_ok = 1'b1;
    got_data = 8'h00; got_to = 1'b0;
    while (!done_seen && cyc < BUDGET) begin
      @(negedge iCLK);
      cyc++;
      if (LCD_EN && !prev_en) begin
        LCD_DATA = tx_data[(pulses < tx_len) ? pulses : tx_len - 1];
        pulses++;
        width = 0;
      end
      if (LCD_EN) width++;
      if (!LCD_EN && prev_en && width != int'(CLK_DIV)) width_ok = 1'b0;
      if (LCD_RS !== rs || LCD_RW !== 1'b1 || oBusy !== 1'b1) proto_ok = 1'b0;
      if (oDone === 1'b1) begin
        if (LCD_EN) proto_ok = 1'b0;
        done_seen = 1'b1;
        done_cyc = cyc;
        got_data = oDATA;
        got_to = oTimeout;
      end
      if (!hold && cyc == 1) iStart = 1'b0;
      if (repulse && cyc == 20) iStart = 1'b1;
      if (repulse && !hold && cyc == 21) iStart = 1'b0;
      if (wiggle) begin
        iRS = 1'($urandom);
        iPoll = 1'($urandom);
      end
      prev_en = LCD_EN;
    end
    check_eq("done_seen", 32'(done_seen), 32'd1);
    check_eq("latency", done_cyc, LAT_FIRST + (exp_pulses - 1) * LAT_EXTRA);
    check_eq("en_pulses", pulses, exp_pulses);
    check_eq("data", 32'(got_data), 32'(exp_data));
    check_eq("timeout", 32'(got_to), 32'(exp_to));
    check_eq("en_width", 32'(width_ok), 32'd1);
    check_eq("rs_rw_busy_stable", 32'(proto_ok), 32'd1);
    @(negedge iCLK);
    check_eq("busy_after", 32'(oBusy), 32'd0);
    check_eq("rw_after", 32'(LCD_RW), 32'd0);
    check_eq("done_one_cycle", 32'(oDone), 32'd0);
    check_eq("data_held", 32'(oDATA), 32'(exp_data));
    for (int i = 0; i < 40; i++) begin
      @(negedge iCLK);
      if (LCD_EN || oBusy) extra++;
    end
    check_eq("no_retrigger", extra, 0);
    iStart = 1'b0;
    iRS = 1'b0;
    iPoll = 1'b0;
  endtask

  task automatic reset_mid_txn();
    bit en_seen;
    int dones;
    en_seen = 1'b0;
    dones = 0;
    tx_data[0] = 8'h5A;
    tx_len = 1;
    @(negedge iCLK);
    iRS = 1'b1;
    iStart = 1'b1;
    for (int i = 0; i < 50 && !en_seen; i++) begin
      @(negedge iCLK);
      if (LCD_EN) en_seen = 1'b1;
    end
    check_eq("rst_en_seen", 32'(en_seen), 32'd1);
    repeat (5) @(negedge iCLK);
    iRST_N = 1'b0;
    #1;
    check_eq("rst_en", 32'(LCD_EN), 32'd0);
    check_eq("rst_rw", 32'(LCD_RW), 32'd0);
    check_eq("rst_busy", 32'(oBusy), 32'd0);
    check_eq("rst_data", 32'(oDATA), 32'd0);
    iStart = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge iCLK);
      if (oDone) dones++;
    end
    iRST_N = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge iCLK);
      if (oDone) dones++;
    end
    check_eq("rst_no_done", dones, 0);
  endtask

  initial begin
    repeat (3) @(negedge iCLK);
    check_eq("reset_data", 32'(oDATA), 32'd0);
    check_eq("reset_done", 32'(oDone), 32'd0);
    check_eq("reset_busy", 32'(oBusy), 32'd0);
    check_eq("reset_timeout", 32'(oTimeout), 32'd0);
    check_eq("reset_rw", 32'(LCD_RW), 32'd0);
    check_eq("reset_en", 32'(LCD_EN), 32'd0);
    check_eq("reset_rs", 32'(LCD_RS), 32'd0);
    iRST_N = 1'b1;
    repeat (2) @(negedge iCLK);

    // Plain data read
    tx_data[0] = 8'h41;
    tx_len = 1;
    do_txn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Status read with poll request: polls to BF=0 / times out, or a single read
    tx_data[0] = 8'h85; tx_data[1] = 8'h85; tx_data[2] = 8'h85; tx_data[3] = 8'h05;
    tx_len = 4;
    do_txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tx_data[0] = 8'hFF;
    tx_len = 1;
    do_txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tx_data[0] = 8'h80;
    tx_len = 1;
    do_txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // iStart held past completion, then a start pulse while busy
    tx_data[0] = 8'h3C;
    tx_len = 1;
    do_txn(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tx_data[0] = 8'hC3;
    do_txn(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    reset_mid_txn();
    tx_data[0] = 8'h96;
    tx_len = 1;
    do_txn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      int nb;
      nb = int'($urandom_range(0, 10));
      for (int k = 0; k < nb; k++) tx_data[k] = 8'($urandom) | 8'h80;
      tx_data[nb] = 8'($urandom) & 8'h7F;
      tx_len = nb + 1;
      do_txn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
